bp_update_sched: RTL and testbench

Write-port scheduler for the fetch-stage branch predictor tables (PHT 2-bit counters, BTB tag/target). Branch resolutions from execute are buffered in a small FIFO and drained into the single-ported PHT/BTB write port only in cycles when fetch is not using the tables. After reset, and on a flush request (fence.i / context switch), a sweep state machine owns the port and reinitialises every entry. While the sweep runs, predictions are blocked.

---
 rtl/bp_update_sched.sv | 237 +++++++++++++++++++++++
 tb/tb_bp_update_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_sched.sv
// Write-port scheduler for the branch predictor PHT/BTB: buffers resolved-branch updates in a FIFO
// and sweeps both tables after reset/flush. Optional BP_UPD_BYPASS_EN: idle zero-latency update path.
module bp_update_sched #(
    parameter int PHT_SIZE    = 256,
    parameter int BTB_SIZE    = 256,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_req_i,
    output logic                               flush_done_o,
    output logic                               pred_block_o,
    input  logic                               port_busy_i,
    input  logic                               upd_valid_i,
    output logic                               upd_ready_o,
    input  logic [31:0]                        upd_pc_i,
    input  logic [$clog2(PHT_SIZE)-1:0]        upd_idx_i,
    input  logic [1:0]                         upd_ctr_i,
    input  logic                               upd_taken_i,
    input  logic [31:0]                        upd_target_i,
    output logic                               pht_we_o,
    output logic [$clog2(PHT_SIZE)-1:0]        pht_waddr_o,
    output logic [1:0]                         pht_wdata_o,
    output logic                               btb_we_o,
    output logic [$clog2(BTB_SIZE)-1:0]        btb_waddr_o,
    output logic [32-$clog2(BTB_SIZE)-1-1:0]   btb_wtag_o,
    output logic [31:0]                        btb_wtarget_o
);

    localparam int PHT_AW   = $clog2(PHT_SIZE);
    localparam int BTB_AW   = $clog2(BTB_SIZE);
    localparam int TAG_W    = 32 - BTB_AW - 1;
    localparam int SWEEP_N  = (PHT_SIZE > BTB_SIZE) ? PHT_SIZE : BTB_SIZE;
    localparam int SWEEP_AW = $clog2(SWEEP_N);
    localparam int QA       = $clog2(QUEUE_DEPTH);

    localparam logic [SWEEP_AW:0]   PHT_LIM_C    = (SWEEP_AW+1)'(PHT_SIZE);
    localparam logic [SWEEP_AW:0]   BTB_LIM_C    = (SWEEP_AW+1)'(BTB_SIZE);
    localparam logic [SWEEP_AW-1:0] SWEEP_LAST_C = SWEEP_AW'(SWEEP_N - 1);
    localparam logic [QA:0]         QDEPTH_C     = (QA+1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // pc bit 0 is never needed: BTB index and tag both come from pc[31:1]
    typedef struct packed {
        logic [30:0]       pc_hi;
        logic [PHT_AW-1:0] idx;
        logic [1:0]        ctr;
        logic              taken;
        logic [31:0]       target;
    } upd_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            if (ctr == 2'b11) res = 2'b11;
            else              res = ctr + 2'b01;
        end else begin
            if (ctr == 2'b00) res = 2'b00;
            else              res = ctr - 2'b01;
        end
        return res;
    endfunction

    state_t              state_r;
    logic [SWEEP_AW-1:0] sweep_idx_r;
    logic                pred_block_r;
    logic                upd_ready_r;
    logic                flush_done_r;
    upd_t                fifo_mem_r [QUEUE_DEPTH];
    logic [QA-1:0]       wr_ptr_r;
    logic [QA-1:0]       rd_ptr_r;
    logic [QA:0]         count_r;

    logic                run_s;
    logic                empty_s;
    logic                drain_s;
    logic                bypass_s;
    logic                push_s;
    logic [QA:0]         count_nxt_s;
    logic [SWEEP_AW:0]   sweep_ext_s;
    upd_t                upd_in_s;
    upd_t                head_s;
    upd_t                wr_src_s;

    assign run_s       = (state_r == ST_RUN);
    assign empty_s     = (count_r == {(QA+1){1'b0}});
    assign drain_s     = run_s && !flush_req_i && !empty_s && !port_busy_i;
`ifdef BP_UPD_BYPASS_EN
    assign bypass_s    = run_s && !flush_req_i && empty_s && !port_busy_i && upd_valid_i;
`else
    assign bypass_s    = 1'b0;
`endif
    // upd_ready_r is only ever set in RUN, so it already implies !full
    assign push_s      = run_s && !flush_req_i && upd_valid_i && upd_ready_r && !bypass_s;
    assign sweep_ext_s = {1'b0, sweep_idx_r};
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign wr_src_s    = bypass_s ? upd_in_s : head_s;

    assign upd_in_s.pc_hi  = upd_pc_i[31:1];
    assign upd_in_s.idx    = upd_idx_i;
    assign upd_in_s.ctr    = upd_ctr_i;
    assign upd_in_s.taken  = upd_taken_i;
    assign upd_in_s.target = upd_target_i;

    assign pred_block_o = pred_block_r;
    assign upd_ready_o  = upd_ready_r;
    assign flush_done_o = flush_done_r;

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, drain_s})
            2'b10:   count_nxt_s = count_r + (QA+1)'(1);
            2'b01:   count_nxt_s = count_r - (QA+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Table write port: sweep writes in INIT/FLUSH, drained or bypassed update in RUN
    always_comb begin
        pht_we_o      = 1'b0;
        pht_waddr_o   = {PHT_AW{1'b0}};
        pht_wdata_o   = 2'b00;
        btb_we_o      = 1'b0;
        btb_waddr_o   = {BTB_AW{1'b0}};
        btb_wtag_o    = {TAG_W{1'b0}};
        btb_wtarget_o = 32'h0000_0000;
        case (state_r)
            ST_INIT, ST_FLUSH: begin
                pht_we_o    = (sweep_ext_s < PHT_LIM_C);
                pht_waddr_o = sweep_idx_r[PHT_AW-1:0];
                pht_wdata_o = 2'b01;
                btb_we_o    = (sweep_ext_s < BTB_LIM_C);
                btb_waddr_o = sweep_idx_r[BTB_AW-1:0];
            end
            ST_RUN: begin
                if (drain_s || bypass_s) begin
                    pht_we_o    = 1'b1;
                    pht_waddr_o = wr_src_s.idx;
                    pht_wdata_o = ctr_next(wr_src_s.ctr, wr_src_s.taken);
                    btb_we_o    = 1'b1;
                    btb_waddr_o = wr_src_s.pc_hi[BTB_AW-1:0];
                    // a not-taken resolution invalidates the BTB entry
                    if (wr_src_s.taken) begin
                        btb_wtag_o    = wr_src_s.pc_hi[30:BTB_AW];
                        btb_wtarget_o = wr_src_s.target;
                    end else begin
                        btb_wtag_o    = {TAG_W{1'b0}};
                        btb_wtarget_o = 32'h0000_0000;
                    end
                end else begin
                    pht_we_o = 1'b0;
                    btb_we_o = 1'b0;
                end
            end
            default: begin
                pht_we_o = 1'b0;
                btb_we_o = 1'b0;
            end
        endcase
    end

    // Control FSM: sweep sequencing, flush entry and registered status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_INIT;
            sweep_idx_r  <= {SWEEP_AW{1'b0}};
            pred_block_r <= 1'b1;
            upd_ready_r  <= 1'b0;
            flush_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT, ST_FLUSH: begin
                    if (sweep_idx_r == SWEEP_LAST_C) begin
                        state_r      <= ST_RUN;
                        sweep_idx_r  <= {SWEEP_AW{1'b0}};
                        pred_block_r <= 1'b0;
                        upd_ready_r  <= 1'b1;
                        flush_done_r <= 1'b1;
                    end else begin
                        sweep_idx_r  <= sweep_idx_r + SWEEP_AW'(1);
                        pred_block_r <= 1'b1;
                        upd_ready_r  <= 1'b0;
                        flush_done_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    flush_done_r <= 1'b0;
                    if (flush_req_i) begin
                        state_r      <= ST_FLUSH;
                        sweep_idx_r  <= {SWEEP_AW{1'b0}};
                        pred_block_r <= 1'b1;
                        upd_ready_r  <= 1'b0;
                    end else begin
                        pred_block_r <= 1'b0;
                        upd_ready_r  <= (count_nxt_s != QDEPTH_C);
                    end
                end
                default: begin
                    state_r      <= ST_INIT;
                    sweep_idx_r  <= {SWEEP_AW{1'b0}};
                    pred_block_r <= 1'b1;
                    upd_ready_r  <= 1'b0;
                    flush_done_r <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a flush discards every queued update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {QA{1'b0}};
            rd_ptr_r <= {QA{1'b0}};
            count_r  <= {(QA+1){1'b0}};
        end else if (run_s && flush_req_i) begin
            wr_ptr_r <= {QA{1'b0}};
            rd_ptr_r <= {QA{1'b0}};
            count_r  <= {(QA+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + QA'(1);
            if (drain_s) rd_ptr_r <= rd_ptr_r + QA'(1);
            count_r <= count_nxt_s;
        end
    end

    // FIFO storage; contents are only meaningful below count_r
    always_ff @(posedge clk_i) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= upd_in_s;
    end

endmodule

// File: tb/tb_bp_update_sched.sv
// Self-checking bench for bp_update_sched: directed vectors, multi-cycle corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_bp_update_sched;

    localparam int PHT_SIZE = 256;
    localparam int BTB_SIZE = 256;
    localparam int QD       = 4;
    localparam int BTB_AW   = 8;
    localparam int SWEEP_N  = 256;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_req_i, flush_done_o, pred_block_o, port_busy_i;
    logic        upd_valid_i, upd_ready_o, upd_taken_i;
    logic [31:0] upd_pc_i, upd_target_i, btb_wtarget_o;
    logic [7:0]  upd_idx_i, pht_waddr_o, btb_waddr_o;
    logic [1:0]  upd_ctr_i, pht_wdata_o;
    logic        pht_we_o, btb_we_o;
    logic [22:0] btb_wtag_o;

    always #5 clk_i = ~clk_i;

    bp_update_sched #(.PHT_SIZE(PHT_SIZE), .BTB_SIZE(BTB_SIZE), .QUEUE_DEPTH(QD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_req_i(flush_req_i), .flush_done_o(flush_done_o),
        .pred_block_o(pred_block_o), .port_busy_i(port_busy_i), .upd_valid_i(upd_valid_i),
        .upd_ready_o(upd_ready_o), .upd_pc_i(upd_pc_i), .upd_idx_i(upd_idx_i), .upd_ctr_i(upd_ctr_i),
        .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i), .pht_we_o(pht_we_o),
        .pht_waddr_o(pht_waddr_o), .pht_wdata_o(pht_wdata_o), .btb_we_o(btb_we_o),
        .btb_waddr_o(btb_waddr_o), .btb_wtag_o(btb_wtag_o), .btb_wtarget_o(btb_wtarget_o)
    );

`ifdef BP_UPD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  idx;
        logic [1:0]  ctr;
        logic        taken;
        logic [31:0] tgt;
    } upd_t;

    typedef struct {
        upd_t        u;
        logic [1:0]  e_pht;
        logic [7:0]  e_baddr;
        logic [22:0] e_tag;
        logic [31:0] e_tgt;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;
    bit   rdy_seen;
    vec_t vecs [7];

    // reference model state
    upd_t mq[$];
    bit   m_sweep;
    int   m_i;
    bit   m_done_pend;

    always @(negedge clk_i) if (rst_ni === 1'b1 && flush_done_o === 1'b1) done_cnt++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic upd_t cur_in();
        upd_t u;
        u.pc = upd_pc_i; u.idx = upd_idx_i; u.ctr = upd_ctr_i;
        u.taken = upd_taken_i; u.tgt = upd_target_i;
        return u;
    endfunction

    task automatic drive(input bit v, input upd_t u);
        upd_valid_i = v; upd_pc_i = u.pc; upd_idx_i = u.idx; upd_ctr_i = u.ctr;
        upd_taken_i = u.taken; upd_target_i = u.tgt;
    endtask

    function automatic upd_t rand_upd();
        upd_t u;
        u.pc = $urandom; u.idx = 8'($urandom_range(0, 255)); u.ctr = 2'($urandom_range(0, 3));
        u.taken = 1'($urandom_range(0, 1)); u.tgt = $urandom;
        return u;
    endfunction

    task automatic model_reset();
        mq.delete(); m_sweep = 1'b1; m_i = 0; m_done_pend = 1'b0;
    endtask

    // expected outputs for the current cycle, from the model state and the applied inputs
    task automatic model_check();
        bit   e_we;
        upd_t w;
        int   e_ctr;
        if (m_sweep) begin
            chk("sweep_block", pred_block_o, 1); chk("sweep_ready", upd_ready_o, 0);
            chk("sweep_done", flush_done_o, 0);
            chk("sweep_pht_we", pht_we_o, m_i < PHT_SIZE); chk("sweep_btb_we", btb_we_o, m_i < BTB_SIZE);
            chk("sweep_pht_addr", pht_waddr_o, m_i); chk("sweep_pht_data", pht_wdata_o, 1);
            chk("sweep_btb_addr", btb_waddr_o, m_i); chk("sweep_btb_tag", btb_wtag_o, 0);
            chk("sweep_btb_tgt", btb_wtarget_o, 0);
        end else begin
            chk("run_block", pred_block_o, 0); chk("run_ready", upd_ready_o, mq.size() < QD);
            chk("run_done", flush_done_o, m_done_pend);
            e_we = 1'b0;
            if (!flush_req_i && !port_busy_i) begin
                if (mq.size() > 0) begin e_we = 1'b1; w = mq[0]; end
                else if (BYP && upd_valid_i) begin e_we = 1'b1; w = cur_in(); end
            end
            chk("pht_we", pht_we_o, e_we); chk("btb_we", btb_we_o, e_we);
            if (e_we) begin
                e_ctr = w.taken ? ((w.ctr == 3) ? 3 : w.ctr + 1) : ((w.ctr == 0) ? 0 : w.ctr - 1);
                chk("pht_addr", pht_waddr_o, w.idx); chk("pht_data", pht_wdata_o, e_ctr);
                chk("btb_addr", btb_waddr_o, (w.pc >> 1) % BTB_SIZE);
                chk("btb_tag", btb_wtag_o, w.taken ? (w.pc >> (BTB_AW + 1)) : 0);
                chk("btb_tgt", btb_wtarget_o, w.taken ? w.tgt : 0);
            end
        end
    endtask

    // model state advance at the clock edge, using the inputs the DUT sampled
    task automatic model_update();
        bit acc, popd, byp;
        if (m_sweep) begin
            m_i++;
            if (m_i == SWEEP_N) begin m_sweep = 1'b0; m_i = 0; m_done_pend = 1'b1; end
        end else begin
            m_done_pend = 1'b0;
            if (flush_req_i) begin
                mq.delete(); m_sweep = 1'b1; m_i = 0;
            end else begin
                acc  = upd_valid_i && (mq.size() < QD);
                popd = !port_busy_i && (mq.size() > 0);
                byp  = BYP && !port_busy_i && (mq.size() == 0) && upd_valid_i;
                if (popd) void'(mq.pop_front());
                if (acc && !byp) mq.push_back(cur_in());
            end
        end
    endtask

    task automatic table_check(input int v);
        chk("vec_pht_we", pht_we_o, 1); chk("vec_pht_addr", pht_waddr_o, vecs[v].u.idx);
        chk("vec_pht_data", pht_wdata_o, vecs[v].e_pht); chk("vec_btb_we", btb_we_o, 1);
        chk("vec_btb_addr", btb_waddr_o, vecs[v].e_baddr); chk("vec_btb_tag", btb_wtag_o, vecs[v].e_tag);
        chk("vec_btb_tgt", btb_wtarget_o, vecs[v].e_tgt);
    endtask

    task automatic cycle(input bit tab, input int v);
        @(negedge clk_i);
        rdy_seen = upd_ready_o;
        model_check();
        if (tab) table_check(v);
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        upd_valid_i = 1'b0; port_busy_i = 1'b0; flush_req_i = 1'b0;
        for (int k = 0; k < n; k++) cycle(1'b0, 0);
    endtask

    initial begin
        vecs[0] = '{'{32'h8000_0010, 8'd5,   2'd3, 1'b1, 32'h8000_0100}, 2'd3, 8'h08, 23'h40_0000, 32'h8000_0100};
        vecs[1] = '{'{32'h0000_1234, 8'd9,   2'd0, 1'b0, 32'h1111_2222}, 2'd0, 8'h1A, 23'h0,       32'h0};
        vecs[2] = '{'{32'h0000_0FFE, 8'd255, 2'd1, 1'b1, 32'h1234_5678}, 2'd2, 8'hFF, 23'h7,       32'h1234_5678};
        vecs[3] = '{'{32'hFFFF_FFFE, 8'd0,   2'd2, 1'b0, 32'h5555_5555}, 2'd1, 8'hFF, 23'h0,       32'h0};
        vecs[4] = '{'{32'h0000_0200, 8'd128, 2'd0, 1'b1, 32'h0000_0004}, 2'd1, 8'h00, 23'h1,       32'h0000_0004};
        vecs[5] = '{'{32'h8000_0002, 8'd7,   2'd3, 1'b0, 32'hAAAA_AAAA}, 2'd2, 8'h01, 23'h0,       32'h0};
        vecs[6] = '{'{32'h0000_0010, 8'd3,   2'd2, 1'b1, 32'hDEAD_BEEF}, 2'd3, 8'h08, 23'h0,       32'hDEAD_BEEF};

        rst_ni = 1'b0; flush_req_i = 1'b0; port_busy_i = 1'b0;
        drive(1'b0, '{32'h0, 8'h0, 2'd0, 1'b0, 32'h0});
        @(negedge clk_i);
        chk("rst_block", pred_block_o, 1); chk("rst_ready", upd_ready_o, 0); chk("rst_done", flush_done_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        model_reset();

        // power-up sweep followed by a single done pulse
        idle(SWEEP_N + 3);
        chk("init_done_pulses", done_cnt, 1);

        // directed vectors: write appears in the handshake cycle with bypass, one cycle later without
        for (int v = 0; v < 7; v++) begin
            drive(1'b1, vecs[v].u);
`ifdef BP_UPD_BYPASS_EN
            cycle(1'b1, v);
            upd_valid_i = 1'b0;
`else
            cycle(1'b0, v);
            upd_valid_i = 1'b0;
            cycle(1'b1, v);
`endif
            idle(1);
        end

        // fill the queue behind a busy port, then release it
        port_busy_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, rand_upd());
            cycle(1'b0, 0);
        end
        drive(1'b1, rand_upd());
        @(negedge clk_i);
        chk("full_ready_low", upd_ready_o, 0);
        @(posedge clk_i); model_update(); #1;
        cycle(1'b0, 0);
        port_busy_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 0);
            if (rdy_seen) upd_valid_i = 1'b0;
        end
        chk("full_drained_ready", upd_ready_o, 1);
        idle(2);

        // queued updates are discarded by a flush; flush_req held into the sweep is ignored
        port_busy_i = 1'b1;
        for (int k = 0; k < 2; k++) begin drive(1'b1, rand_upd()); cycle(1'b0, 0); end
        upd_valid_i = 1'b0; port_busy_i = 1'b0; flush_req_i = 1'b1;
        for (int k = 0; k < 3; k++) cycle(1'b0, 0);
        done_cnt = 0;
        idle(SWEEP_N + 2);
        chk("flush_done_pulses", done_cnt, 1);

        // randomized traffic against the model
        for (int k = 0; k < 2500; k++) begin
            drive(1'($urandom_range(0, 1)), rand_upd());
            port_busy_i = ($urandom_range(0, 9) < 4);
            flush_req_i = ($urandom_range(0, 299) == 0);
            cycle(1'b0, 0);
        end
        idle(SWEEP_N + 2);

        // asynchronous reset in the middle of queued traffic
        port_busy_i = 1'b1;
        for (int k = 0; k < 2; k++) begin drive(1'b1, rand_upd()); cycle(1'b0, 0); end
        rst_ni = 1'b0; upd_valid_i = 1'b0; port_busy_i = 1'b0;
        #1;
        chk("midrst_block", pred_block_o, 1); chk("midrst_ready", upd_ready_o, 0);
        chk("midrst_done", flush_done_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        model_reset();
        idle(SWEEP_N + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
